// File: rtl/decode_pkg.sv
// Shared decode types for the LEGv8 ID stage.
// Opcode keys, extender modes and the per-instruction control bundle.
package decode_pkg;

    typedef enum logic [1:0] {
        ZERO12 = 2'b00,
        SIGN9  = 2'b01,
        SIGN19 = 2'b10,
        SIGN26 = 2'b11
    } ext_sel_e;

    // Keys compared against the top bits of instr[31:21]
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    localparam logic [4:0]  XZR = 5'd31;

    typedef struct packed {
        logic use_imm;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic reads_rn;
        logic reads_rm;
        logic reads_rt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instr_decode.sv
// Combinational LEGv8 opcode decoder for the ID stage.
// Produces the control bundle and the immediate-extender mode.
module instr_decode
    import decode_pkg::*;
(
    input  logic [10:0] i_op,
    input  logic        i_valid,
    output ctrl_t       o_ctrl,
    output ext_sel_e    o_ext_sel
);

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_ext_sel = ZERO12;
        if (i_valid) begin
            unique case (1'b1)
                (i_op[10:1] == OP_ADDI),
                (i_op[10:1] == OP_SUBI): begin
                    o_ctrl.use_imm   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.reads_rn  = 1'b1;
                end
                (i_op == OP_LDUR): begin
                    o_ext_sel        = SIGN9;
                    o_ctrl.use_imm   = 1'b1;
                    o_ctrl.mem_read  = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.reads_rn  = 1'b1;
                end
                (i_op == OP_STUR): begin
                    o_ext_sel        = SIGN9;
                    o_ctrl.use_imm   = 1'b1;
                    o_ctrl.mem_write = 1'b1;
                    o_ctrl.reads_rn  = 1'b1;
                    o_ctrl.reads_rt  = 1'b1;
                end
                (i_op == OP_ADDS),
                (i_op == OP_SUBS): begin
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.reads_rn  = 1'b1;
                    o_ctrl.reads_rm  = 1'b1;
                end
                (i_op[10:3] == OP_CBZ): begin
                    o_ext_sel       = SIGN19;
                    o_ctrl.reads_rt = 1'b1;
                end
                (i_op[10:3] == OP_BCOND): begin
                    o_ext_sel = SIGN19;
                end
                (i_op[10:5] == OP_B): begin
                    o_ext_sel = SIGN26;
                end
                default: begin
                    o_ctrl    = CTRL_NOP;
                    o_ext_sel = ZERO12;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// LEGv8 ID-stage controller: decode, load-use stall, branch squash,
// ID/EX control register and a saturating stall-cycle counter.
module decode_hazard_ctrl
    import decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr_id,
    input  logic             id_valid,
    input  logic             br_taken,
    output logic [1:0]       ext_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ex_valid,
    output logic [1:0]       ex_ext_sel,
    output logic             ex_use_imm,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t      w_ctrl;
    ext_sel_e   w_ext_sel;
    logic [4:0] w_rn;
    logic [4:0] w_rm;
    logic [4:0] w_rt;
    logic       w_match;
    logic       w_load_use;
    logic       w_stall;
    logic       w_bubble;
    logic       w_unused;

    logic             r_ex_valid;
    ext_sel_e         r_ex_ext_sel;
    logic             r_ex_use_imm;
    logic             r_ex_mem_read;
    logic             r_ex_mem_write;
    logic             r_ex_reg_write;
    logic [4:0]       r_ex_rd;
    logic [CNT_W-1:0] r_stall_cnt;

    instr_decode u_dec (
        .i_op      (instr_id[31:21]),
        .i_valid   (id_valid),
        .o_ctrl    (w_ctrl),
        .o_ext_sel (w_ext_sel)
    );

    assign w_unused = ^instr_id[15:10];

    assign w_rn = instr_id[9:5];
    assign w_rm = instr_id[20:16];
    assign w_rt = instr_id[4:0];

    assign w_match = (w_ctrl.reads_rn && (w_rn == r_ex_rd))
                   | (w_ctrl.reads_rm && (w_rm == r_ex_rd))
                   | (w_ctrl.reads_rt && (w_rt == r_ex_rd));

    assign w_load_use = id_valid && r_ex_valid && r_ex_mem_read
                      && (r_ex_rd != XZR) && w_match;

    // A taken branch squashes the dependent instruction anyway
    assign w_stall  = w_load_use && !br_taken;
    assign w_bubble = w_stall || br_taken;

    assign ext_sel    = w_ext_sel;
    assign pc_write   = !w_stall;
    assign ifid_write = !w_stall;
    assign ifid_flush = br_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_ext_sel   <= ZERO12;
            r_ex_use_imm   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_rd        <= 5'd0;
        end else if (w_bubble) begin
            r_ex_valid     <= 1'b0;
            r_ex_ext_sel   <= ZERO12;
            r_ex_use_imm   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_rd        <= 5'd0;
        end else begin
            r_ex_valid     <= id_valid;
            r_ex_ext_sel   <= w_ext_sel;
            r_ex_use_imm   <= w_ctrl.use_imm;
            r_ex_mem_read  <= w_ctrl.mem_read;
            r_ex_mem_write <= w_ctrl.mem_write;
            r_ex_reg_write <= w_ctrl.reg_write;
            r_ex_rd        <= id_valid ? instr_id[4:0] : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_ext_sel   = r_ex_ext_sel;
    assign ex_use_imm   = r_ex_use_imm;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_rd        = r_ex_rd;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

ID-stage controller for the 5-stage LEGv8 pipeline. It decodes the instruction in IF/ID, selects the immediate-extension mode for the ID-stage extender (zero-extend imm12, or sign-extend DAddr9, CondBr19 or BrAddr26), and owns the ID/EX control register. It detects load-use hazards and stalls PC and IF/ID for one cycle. It squashes wrong-path instructions on a taken branch, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- instr_id  in  32  instruction in IF/ID
- id_valid  in  1  IF/ID holds a real instruction
- br_taken  in  1  branch resolved taken in EX this cycle
- ext_sel  out  2  extender mode for instr_id (combinational)
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a bubble
- ex_valid  out  1  ID/EX holds a real instruction
- ex_ext_sel  out  2  registered ext_sel
- ex_use_imm  out  1  ALU B operand is the extended immediate
- ex_mem_read  out  1  EX instruction is LDUR
- ex_mem_write  out  1  EX instruction is STUR
- ex_reg_write  out  1  EX instruction writes Rd/Rt
- ex_rd  out  5  destination register of EX instruction
- stall_cnt  out  CNT_W  load-use stall cycles, saturating

## Operation
- Decode, keyed on instr_id[31:21]; ext_sel encoding: 00 ZERO12, 01 SIGN9, 10 SIGN19, 11 SIGN26.
  - ADDI 1001000100x / SUBI 1101000100x: ZERO12; use_imm, reg_write; reads Rn.
  - LDUR 11111000010: SIGN9; use_imm, mem_read, reg_write; reads Rn.
  - STUR 11111000000: SIGN9; use_imm, mem_write; reads Rn and Rt.
  - ADDS 10101011000 / SUBS 11101011000: ext_sel 00, use_imm=0; reg_write; reads Rn and Rm.
  - CBZ 10110100xxx / B.cond 01010100xxx: SIGN19; CBZ reads Rt.
  - B 000101xxxxx: SIGN26; no register reads.
  - Unrecognised opcodes and id_valid=0: treated as NOP. ext_sel=00, all controls 0, no register reads.
- Register fields: Rn=[9:5], Rm=[20:16], Rt/Rd=[4:0].
- Load-use hazard: ex_valid & ex_mem_read & ex_rd!=31 & (any register read by instr_id equals ex_rd) & id_valid.
  - Response: pc_write=0, ifid_write=0; a bubble (ex_valid=0, all ex_* controls 0) enters ID/EX.
- Taken branch: br_taken=1 gives ifid_flush=1, pc_write=1, ifid_write=1; a bubble enters ID/EX.
- Priority: br_taken over load-use. A stall coinciding with a taken branch does not stall and does not count.
- Normal cycle: pc_write=1, ifid_write=1, ifid_flush=0; decoded fields load into ID/EX.
- stall_cnt: +1 per load-use stall cycle; holds at all-ones (no wrap).

## Timing
- ext_sel, pc_write, ifid_write, ifid_flush: combinational in the same cycle as instr_id/br_taken.
- ex_* outputs: registered, valid the cycle after decode (1-cycle latency).
- A stall lasts exactly one cycle: the inserted bubble clears the hazard, so the held instruction issues next cycle with the load in MEM.
- Back-to-back loads feeding each other each cost one stall.
- Reset (async assert, sync-safe deassert) forces:
  - all ex_* = 0 and stall_cnt = 0;
  - pc_write=1, ifid_write=1, ifid_flush=0 (combinational from cleared state).
- Reset mid-stall: the stall ends immediately; the held instruction is re-fetched per PC reset.

## Structure
- Package decode_pkg:
  - ext_sel_e enum (ZERO12, SIGN9, SIGN19, SIGN26);
  - opcode constants;
  - ctrl_t packed struct (use_imm, mem_read, mem_write, reg_write, reads_rn, reads_rm, reads_rt).
- Sub-module instr_decode: purely combinational; instr_id/id_valid to ctrl_t + ext_sel.
- Top holds the hazard logic, ID/EX register and counter.

## Test plan
- Reset: reset_n=0 mid-run -> all ex_*=0, stall_cnt=0, pc_write=1 asynchronously.
- Extension modes, each with id_valid=1:
  - ADDI X1,X2,#0xFFF -> ext_sel=00, next cycle ex_use_imm=1, ex_rd=1.
  - LDUR -> 01. CBZ -> 10. B -> 11.
- Load-use stall: LDUR X3,[X4,#0] followed by ADDS X5,X3,X6 -> one cycle pc_write=0, ifid_write=0, ex_valid=0; then ADDS issues; stall_cnt=1.
- XZR / no-hazard cases:
  - LDUR X31 then ADDS reading X31 -> no stall.
  - LDUR X3 then B -> no stall.
- Branch priority: load-use condition with br_taken=1 -> ifid_flush=1, pc_write=1, bubble into EX, stall_cnt unchanged.
- Saturation: CNT_W=4, 20 stall events -> stall_cnt holds 4'hF.
